// File: rtl/hwpe_stream_burst_sequencer_if.sv
// rtl/hwpe_stream_burst_sequencer_if.sv - source-control handshake bundle between the burst sequencer and a stream source
interface hwpe_stream_burst_sequencer_if #(
    parameter int unsigned ROT_WIDTH = 2
);

    logic                 stream_valid;
    logic                 stream_ready;
    logic                 enable;
    logic                 randomize;
    logic                 new_rotation;
    logic                 force_invalid;
    logic [ROT_WIDTH-1:0] rotation;

    // master: the sequencer (drives source controls, monitors the handshake)
    modport master (
        input  stream_valid,
        input  stream_ready,
        output enable,
        output randomize,
        output new_rotation,
        output force_invalid,
        output rotation
    );

    // slave: the controlled source together with its sink
    modport slave (
        output stream_valid,
        output stream_ready,
        input  enable,
        input  randomize,
        input  new_rotation,
        input  force_invalid,
        input  rotation
    );

endinterface

// File: rtl/hwpe_stream_burst_sequencer.sv
// rtl/hwpe_stream_burst_sequencer.sv - burst/gap sequencer for a stream source; HWPE_STREAM_BURST_SEQ_PERF_EN adds the stall counter
module hwpe_stream_burst_sequencer #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  LEN_WIDTH  = 16,
    parameter int unsigned  NB_WIDTH   = 8,
    localparam int unsigned NB         = DATA_WIDTH / 8,
    localparam int unsigned ROT_WIDTH  = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                 clk_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] burst_len_i,
    input  logic [NB_WIDTH-1:0]  nb_bursts_i,
    input  logic [NB_WIDTH-1:0]  gap_i,
    input  logic [ROT_WIDTH-1:0] rotation_i,
    hwpe_stream_burst_sequencer_if.master ctrl,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LEN_WIDTH-1:0] beat_cnt_o,
    output logic [NB_WIDTH-1:0]  burst_idx_o,
    output logic [31:0]          stall_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        GAP,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic [NB_WIDTH-1:0]  nb_q;
    logic [NB_WIDTH-1:0]  gap_q;
    logic [ROT_WIDTH-1:0] rot_q;
    logic [LEN_WIDTH-1:0] beat_q;
    logic [NB_WIDTH-1:0]  idx_q;
    logic [NB_WIDTH-1:0]  gap_cnt_q;
    logic                 first_q;

    logic beat;
    logic burst_end;
    logic last_burst;
    logic enable, randomize, new_rotation, force_invalid, busy, done;

    assign beat       = (state_q == RUN) & ctrl.stream_valid & ctrl.stream_ready;
    assign burst_end  = beat & (beat_q == len_q - LEN_WIDTH'(1));
    assign last_burst = (idx_q == nb_q - NB_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        enable        = 1'b0;
        randomize     = 1'b0;
        new_rotation  = 1'b0;
        force_invalid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                randomize = 1'b1;
                busy      = 1'b1;
                if (len_q == '0 || nb_q == '0) state_d = DONE;
                else                           state_d = RUN;
            end
            RUN: begin
                enable       = 1'b1;
                busy         = 1'b1;
                new_rotation = first_q;
                if (burst_end) begin
                    if (last_burst)        state_d = DONE;
                    else if (gap_q == '0)  state_d = RUN;
                    else                   state_d = GAP;
                end
            end
            GAP: begin
                enable        = 1'b1;
                force_invalid = 1'b1;
                busy          = 1'b1;
                if (gap_cnt_q == NB_WIDTH'(1)) state_d = RUN;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            nb_q      <= '0;
            gap_q     <= '0;
            rot_q     <= '0;
            beat_q    <= '0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // config is captured on the edge into LOAD so LOAD already sees it
                    if (start_i) begin
                        len_q  <= burst_len_i;
                        nb_q   <= nb_bursts_i;
                        gap_q  <= gap_i;
                        rot_q  <= rotation_i;
                        beat_q <= '0;
                        idx_q  <= '0;
                    end
                end
                LOAD: begin
                    beat_q    <= '0;
                    idx_q     <= '0;
                    gap_cnt_q <= '0;
                    first_q   <= 1'b1;
                end
                RUN: begin
                    first_q <= 1'b0;
                    if (burst_end) begin
                        beat_q    <= '0;
                        idx_q     <= idx_q + NB_WIDTH'(1);
                        first_q   <= 1'b1;
                        gap_cnt_q <= gap_q;
                    end else if (beat) begin
                        beat_q <= beat_q + LEN_WIDTH'(1);
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q - NB_WIDTH'(1);
                end
                DONE: begin
                    beat_q <= '0;
                    idx_q  <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef HWPE_STREAM_BURST_SEQ_PERF_EN
    logic [31:0] stall_q;

    // value stays visible through DONE and is dropped on the way back to IDLE
    always_ff @(posedge clk_i) begin
        if (clear_i || state_q == LOAD || state_q == DONE) begin
            stall_q <= '0;
        end else if (state_q == RUN && ctrl.stream_valid && !ctrl.stream_ready
                     && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign ctrl.enable        = enable;
    assign ctrl.randomize     = randomize;
    assign ctrl.new_rotation  = new_rotation;
    assign ctrl.force_invalid = force_invalid;
    assign ctrl.rotation      = busy ? rot_q : '0;
    assign busy_o             = busy;
    assign done_o             = done;
    assign beat_cnt_o         = beat_q;
    assign burst_idx_o        = idx_q;

endmodule
